// File: rtl/cpu_control.sv
// Multi-cycle control unit for the 8-bit four-register teaching CPU.
// Owns PC and IR and sequences the external register file, ALU and data memory.
module cpu_control #(
  parameter int unsigned PC_WIDTH  = 8,
  parameter logic [7:0]  HALT_WORD = 8'hC3
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                start,
  input  logic [7:0]          instruction,
  input  logic                mem_ready,
  output logic [PC_WIDTH-1:0] address,
  output logic [1:0]          rs_sel,
  output logic [1:0]          rt_sel,
  output logic [1:0]          rd_sel,
  output logic [7:0]          imm,
  output logic                reg_write,
  output logic                wb_sel,
  output logic                mem_read,
  output logic                mem_write,
  output logic                busy,
  output logic                halted
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [1:0] OpAdd   = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpStore = 2'b10;

  localparam logic [PC_WIDTH-1:0] PcOne = PC_WIDTH'(1);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic [PC_WIDTH-1:0] jump_off;

  logic [1:0] rs_sel_q, rs_sel_d;
  logic [1:0] rt_sel_q, rt_sel_d;
  logic [1:0] rd_sel_q, rd_sel_d;
  logic [7:0] imm_q, imm_d;
  logic       reg_write_q, reg_write_d;
  logic       wb_sel_q, wb_sel_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;

  logic [1:0] op_d;
  logic       fields_vis;

  // PC already points past the jump when EXEC adds the offset.
  assign jump_off = {{(PC_WIDTH-6){ir_q[5]}}, ir_q[5:0]};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        ir_d    = instruction;
        pc_d    = pc_q + PcOne;
        state_d = StDecode;
      end
      StDecode: begin
        state_d = (ir_q == HALT_WORD) ? StHalt : StExec;
      end
      StExec: begin
        unique case (ir_q[7:6])
          OpAdd:           state_d = StWb;
          OpLoad, OpStore: state_d = StMem;
          default: begin
            pc_d    = pc_q + jump_off;
            state_d = StFetch;
          end
        endcase
      end
      StMem: begin
        if (mem_ready) state_d = (ir_q[7:6] == OpLoad) ? StWb : StFetch;
      end
      StWb: begin
        state_d = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies are Moore in state_q/ir_q.
  always_comb begin
    op_d        = ir_d[7:6];
    fields_vis  = state_d inside {StDecode, StExec, StMem, StWb};
    rs_sel_d    = fields_vis ? ir_d[5:4] : 2'b00;
    rt_sel_d    = fields_vis ? ir_d[3:2] : 2'b00;
    rd_sel_d    = 2'b00;
    if (fields_vis) rd_sel_d = (op_d == OpLoad) ? ir_d[3:2] : ir_d[1:0];
    imm_d       = fields_vis ? {{6{ir_d[1]}}, ir_d[1:0]} : 8'h00;
    reg_write_d = (state_d == StWb);
    wb_sel_d    = (state_d == StWb) && (op_d == OpLoad);
    mem_read_d  = (state_d == StMem) && (op_d == OpLoad);
    mem_write_d = (state_d == StMem) && (op_d == OpStore);
    busy_d      = !(state_d inside {StIdle, StHalt});
    halted_d    = (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      ir_q        <= 8'h00;
      rs_sel_q    <= 2'b00;
      rt_sel_q    <= 2'b00;
      rd_sel_q    <= 2'b00;
      imm_q       <= 8'h00;
      reg_write_q <= 1'b0;
      wb_sel_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      rs_sel_q    <= rs_sel_d;
      rt_sel_q    <= rt_sel_d;
      rd_sel_q    <= rd_sel_d;
      imm_q       <= imm_d;
      reg_write_q <= reg_write_d;
      wb_sel_q    <= wb_sel_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  assign address   = pc_q;
  assign rs_sel    = rs_sel_q;
  assign rt_sel    = rt_sel_q;
  assign rd_sel    = rd_sel_q;
  assign imm       = imm_q;
  assign reg_write = reg_write_q;
  assign wb_sel    = wb_sel_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_control.sv
// Scoreboard bench for cpu_control: stimulus queues expected strobe events,
// a negedge monitor pops and compares them as the DUT raises its strobes.
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       start = 1'b0;
  logic       mem_ready = 1'b0;
  logic [7:0] instruction;
  logic [7:0] address;
  logic [1:0] rs_sel, rt_sel, rd_sel;
  logic [7:0] imm;
  logic       reg_write, wb_sel, mem_read, mem_write, busy, halted;

  logic [7:0] rom [256];
  assign instruction = rom[address];

  cpu_control #(
    .PC_WIDTH (8),
    .HALT_WORD(8'hC3)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .instruction(instruction),
    .mem_ready  (mem_ready),
    .address    (address),
    .rs_sel     (rs_sel),
    .rt_sel     (rt_sel),
    .rd_sel     (rd_sel),
    .imm        (imm),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 reg_write (f1 rd, f2 wb_sel), 1 mem_read rise (f1 rs, f2 imm),
  //       2 mem_write rise (f1 rs, f2 imm, f3 rt), 3 halted rise.
  typedef struct {
    int kind;
    int f1;
    int f2;
    int f3;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  t0 = 0;
  int  n_wr = 0;
  logic mr_prev = 1'b0, mw_prev = 1'b0, h_prev = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic push(input int k, input int a, input int b, input int c, input int at);
    ev_t e;
    e.kind = k; e.f1 = a; e.f2 = b; e.f3 = c; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int k, input int a, input int b, input int c);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, want none", k, cyc - t0);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.at != cyc - t0 || e.f1 != a || e.f2 != b || e.f3 != c) begin
      n_bad++;
      $display("FAIL event: got kind %0d cyc %0d f %0d/%0d/%0d, want kind %0d cyc %0d f %0d/%0d/%0d",
               k, cyc - t0, a, b, c, e.kind, e.at, e.f1, e.f2, e.f3);
    end
  endtask

  always @(negedge clk) begin
    if (!clear) begin
      if (reg_write) begin
        n_wr++;
        pop_cmp(0, int'(rd_sel), int'(wb_sel), 0);
      end
      if (mem_read && !mr_prev)  pop_cmp(1, int'(rs_sel), int'(imm), 0);
      if (mem_write && !mw_prev) pop_cmp(2, int'(rs_sel), int'(imm), int'(rt_sel));
      if (halted && !h_prev)     pop_cmp(3, 0, 0, 0);
    end
    mr_prev <= mem_read;
    mw_prev <= mem_write;
    h_prev  <= halted;
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_addr", int'(address), 0);
    check("reset_flags", int'({reg_write, mem_read, mem_write, busy, halted, wb_sel}), 0);
    check("reset_fields", int'({rs_sel, rt_sel, rd_sel, imm}), 0);
    clear = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    start = 1'b0;
    check("start_fetch_busy", int'(busy), 1);
    check("start_fetch_addr", int'(address), 0);
  endtask

  task automatic run_until(input int rel);
    while (cyc - t0 < rel) @(negedge clk);
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    check("halt_reached", int'(halted), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int n_rd;
    int rel;

    // Standard program, mem_ready tied high.
    clear_rom();
    rom[0] = 8'h49; rom[1] = 8'h61; rom[2] = 8'h45; rom[3] = 8'h07;
    rom[4] = 8'h79; rom[5] = 8'h2C; rom[6] = 8'hA2; rom[7] = 8'h0D;
    rom[8] = 8'h7B; rom[9] = 8'h1E; rom[10] = 8'hC3;
    do_reset();
    mem_ready = 1'b1;
    push(1, 0, 1, 0, 3);    push(0, 2, 1, 0, 4);
    push(1, 2, 1, 0, 8);    push(0, 0, 1, 0, 9);
    push(1, 0, 1, 0, 13);   push(0, 1, 1, 0, 14);
    push(0, 3, 0, 0, 18);
    push(1, 3, 1, 0, 22);   push(0, 2, 1, 0, 23);
    push(0, 0, 0, 0, 27);
    push(2, 2, 254, 0, 31);
    push(0, 1, 0, 0, 35);
    push(1, 3, 255, 0, 39); push(0, 2, 1, 0, 40);
    push(0, 2, 0, 0, 44);
    push(3, 0, 0, 0, 47);
    wr0 = n_wr;
    launch();
    wait_halt(100);
    @(negedge clk);
    check("prog_regwrite_count", n_wr - wr0, 9);
    check("prog_queue_drained", exp_q.size(), 0);

    // Halt stays sticky under start/mem_ready activity.
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      mem_ready = ~i[0];
      @(negedge clk);
      check("halt_sticky", int'({halted, busy, reg_write, mem_read, mem_write, address}),
            int'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd11}));
    end
    start = 1'b0;

    // Load with three wait cycles, then halt.
    clear_rom();
    rom[0] = 8'h49; rom[1] = 8'hC3;
    do_reset();
    mem_ready = 1'b0;
    push(1, 0, 1, 0, 3); push(0, 2, 1, 0, 7); push(3, 0, 0, 0, 10);
    launch();
    n_rd = 0;
    for (int k = 0; k < 12; k++) begin
      rel = cyc - t0;
      mem_ready = (rel >= 6);
      if (mem_read) n_rd++;
      if (rel == 8) check("wait_refetch_addr", int'(address), 1);
      @(negedge clk);
    end
    check("wait_memread_cycles", n_rd, 4);
    check("wait_queue_drained", exp_q.size(), 0);

    // Jumps: 0 -> 3 -> 4 -> 10 (halt word there).
    clear_rom();
    rom[0] = 8'hC2; rom[3] = 8'hC0; rom[4] = 8'hC5; rom[10] = 8'hC3;
    do_reset();
    mem_ready = 1'b1;
    push(3, 0, 0, 0, 11);
    launch();
    run_until(3); check("jump_to_3", int'(address), 3);
    run_until(6); check("jump_to_4", int'(address), 4);
    run_until(9); check("jump_to_10", int'(address), 10);
    wait_halt(20);
    @(negedge clk);
    check("jump_queue_drained", exp_q.size(), 0);

    // Self-loop jump 0xFF at PC 0.
    clear_rom();
    rom[0] = 8'hFF;
    do_reset();
    launch();
    run_until(1); check("loop_pc_inc", int'(address), 1);
    run_until(3); check("loop_back_0", int'(address), 0);
    run_until(6); check("loop_again_0", int'(address), 0);
    run_until(7); check("loop_busy", int'({busy, halted}), 2);

    // Clear during a stalled MEM cycle.
    clear_rom();
    rom[0] = 8'h49;
    do_reset();
    mem_ready = 1'b0;
    push(1, 0, 1, 0, 3);
    launch();
    run_until(4);
    check("midrst_memread", int'(mem_read), 1);
    clear = 1'b1;
    @(negedge clk);
    check("midrst_addr", int'(address), 0);
    check("midrst_flags", int'({busy, halted, reg_write, mem_read, mem_write}), 0);
    check("midrst_fields", int'({rs_sel, rt_sel, rd_sel, imm}), 0);
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      @(negedge clk);
    end
    check("midrst_idle", int'({busy, address}), 0);
    check("final_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
